display_map_writer: RTL
=======================

Name: display_map_writer

Overview:
- Frame-buffer writer on the producer side of the 8x8 RGB LED matrix scan interface.
- Game logic sends single-pixel writes to a back buffer through a valid/ready handshake.
- It can clear the back buffer and can request a commit. On commit, the front and back buffers swap only at a scan-frame boundary, so the matrix scanner never shows a half-drawn frame.
- The front buffer drives the scanner's Red/Green/Blue map inputs directly.

Parameters:
- none. Geometry is fixed at 8 rows x 8 columns x 3 colour planes.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- wr_valid  input  1  pixel write request
- wr_ready  output  1  write accepted when wr_valid && wr_ready
- wr_row  input  3  target row, 0..7
- wr_col  input  3  target column, 0..7
- wr_rgb  input  3  bit2=R, bit1=G, bit0=B; 1 = LED on
- clr_req  input  1  clear back buffer to all-off (single-cycle pulse, sampled in IDLE)
- commit  input  1  request buffer swap (single-cycle pulse, sampled in IDLE)
- scan_com  input  3  scanner's current column counter
- Red_map_display  output  [0:7][0:7]  front red plane, element [row][col], 1 = on
- Green_map_display  output  [0:7][0:7]  front green plane
- Blue_map_display  output  [0:7][0:7]  front blue plane
- busy  output  1  high whenever state != IDLE
- frame_done  output  1  one-cycle pulse the cycle after a swap
- frame_count  output  8  number of completed swaps, wraps 255->0

Behaviour:
- Storage:
  - Two buffers, A and B, each 3 planes x 64 bits, all registers.
  - front_sel chooses which buffer is front; the map outputs are the front buffer's registers with no extra latency.
- Reset (synchronous, clocks where reset=1):
  - Both buffers all zero; front_sel=A; state=IDLE.
  - frame_done=0, frame_count=0, busy=0.
  - Any in-progress CLEAR, WAIT_SWAP or COPY is aborted.
- States: IDLE, CLEAR, WAIT_SWAP, COPY. COPY exists only with the option enabled.
- IDLE request priority, same cycle: clr_req > commit > write.
  - wr_ready = (state==IDLE) && !clr_req && !commit. This is combinational.
- Write:
  - On an accepted write, back[plane][wr_row][wr_col] <= wr_rgb bit for each plane, at the same edge.
  - Visible in the back buffer next cycle. Never affects the front buffer.
  - Overwrites the previous value; there is no OR-merge.
  - A write while not ready is ignored, and wr_valid may be held.
- CLEAR:
  - Entered from IDLE on clr_req; runs 8 cycles.
  - Cycle k zeroes back-buffer row k in all 3 planes, using a 3-bit row counter from 0 to 7.
  - After row 7, returns to IDLE, so wr_ready rises 8 cycles after the clr_req edge.
  - The front buffer is untouched.
- WAIT_SWAP:
  - Entered from IDLE on commit.
  - On the first clock edge in WAIT_SWAP where scan_com==3'd7, front_sel toggles and frame_count increments.
  - Then goes to IDLE, or to COPY if the option is enabled.
  - Latency from commit to swap: 1..8 cycles. If scan_com==7 at the commit edge itself, the swap waits for the next wrap, 8 cycles later.
- frame_done is high exactly one cycle after each swap edge.
- commit or clr_req while busy is ignored; there is no queuing.
- Swapping does not alter contents. Without the option, the new back buffer holds the frame from two commits ago.

Optional Feature:
- Macro: COPY_ON_SWAP_EN
- Defined:
  - After each swap the FSM spends 1 cycle in COPY.
  - COPY copies all 3 new-front planes into the new back buffer in parallel. busy=1 and wr_ready=0 during COPY, and clr_req and commit are ignored.
  - Then returns to IDLE.
  - Incremental drawing starts from the currently displayed frame.
- Undefined:
  - There is no COPY state; the FSM goes from the swap directly to IDLE.
  - The back buffer retains stale contents, and software must clear or redraw it.

Test Plan:
- Reset, then hold idle 20 cycles -> all map outputs 0, wr_ready=1, busy=0, frame_count=0, frame_done never high.
- Write (row 2, col 5, rgb 3'b101), then commit with scan_com cycling 0..7 from 3 -> swap on the edge where scan_com=7, which is 4 cycles after commit.
  - Afterwards Red[2][5]=1, Green[2][5]=0, Blue[2][5]=1, all other bits 0.
  - frame_done pulses once; frame_count=1.
- Fill back buffer all-white with 64 writes, commit, then clr_req -> wr_ready=0 for exactly 8 cycles.
  - Front stays all-ones throughout the clear.
  - Second commit shows all-zero front.
- Same cycle clr_req=1, commit=1, wr_valid=1 -> CLEAR entered, no write, no WAIT_SWAP; commit issued during CLEAR is ignored and frame_count is unchanged.
- Assert reset during WAIT_SWAP with scan_com=5 -> next cycle state IDLE, all buffers 0, no frame_done; 256 commits wrap frame_count to 0.
- COPY_ON_SWAP_EN: write (0,0,R), commit, write (7,7,G), commit -> front shows both pixels.
  - Without the macro, the second front shows only (7,7).

Source files
------------

// File: rtl/display_map_writer.sv
// Double-buffered 8x8 RGB frame writer: pixel writes and clears go to the back buffer, and
// commits swap buffers at a scan-frame boundary. Define COPY_ON_SWAP_EN to seed back from front.
module display_map_writer (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_row,
  input  logic [2:0]        wr_col,
  input  logic [2:0]        wr_rgb,
  input  logic              clr_req,
  input  logic              commit,
  input  logic [2:0]        scan_com,
  output logic [0:7][0:7]   Red_map_display,
  output logic [0:7][0:7]   Green_map_display,
  output logic [0:7][0:7]   Blue_map_display,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_count
);

`ifdef COPY_ON_SWAP_EN
  typedef enum logic [1:0] {StIdle, StClear, StWaitSwap, StCopy} state_e;
`else
  typedef enum logic [1:0] {StIdle, StClear, StWaitSwap} state_e;
`endif

  state_e            state_q;
  logic              front_sel_q;
  logic              back_sel;
  logic [2:0]        row_q;
  logic [0:7][0:7]   red_q   [2];
  logic [0:7][0:7]   green_q [2];
  logic [0:7][0:7]   blue_q  [2];

  assign back_sel          = ~front_sel_q;
  assign busy              = (state_q != StIdle);
  assign wr_ready          = (state_q == StIdle) && !clr_req && !commit;
  assign Red_map_display   = red_q[front_sel_q];
  assign Green_map_display = green_q[front_sel_q];
  assign Blue_map_display  = blue_q[front_sel_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      front_sel_q <= 1'b0;
      row_q       <= 3'd0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
      for (int i = 0; i < 2; i++) begin
        red_q[i]   <= '0;
        green_q[i] <= '0;
        blue_q[i]  <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q <= StClear;
            row_q   <= 3'd0;
          end else if (commit) begin
            state_q <= StWaitSwap;
          end else if (wr_valid) begin
            red_q[back_sel][wr_row][wr_col]   <= wr_rgb[2];
            green_q[back_sel][wr_row][wr_col] <= wr_rgb[1];
            blue_q[back_sel][wr_row][wr_col]  <= wr_rgb[0];
          end
        end
        StClear: begin
          red_q[back_sel][row_q]   <= '0;
          green_q[back_sel][row_q] <= '0;
          blue_q[back_sel][row_q]  <= '0;
          row_q                    <= row_q + 3'd1;
          if (row_q == 3'd7) state_q <= StIdle;
        end
        StWaitSwap: begin
          // Swap only as the scanner wraps so a frame is never shown half old, half new.
          if (scan_com == 3'd7) begin
            front_sel_q <= ~front_sel_q;
            frame_count <= frame_count + 8'd1;
            frame_done  <= 1'b1;
`ifdef COPY_ON_SWAP_EN
            state_q     <= StCopy;
`else
            state_q     <= StIdle;
`endif
          end
        end
`ifdef COPY_ON_SWAP_EN
        StCopy: begin
          red_q[back_sel]   <= red_q[front_sel_q];
          green_q[back_sel] <= green_q[front_sel_q];
          blue_q[back_sel]  <= blue_q[front_sel_q];
          state_q           <= StIdle;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
